aer_spike_decoder: RTL and testbench

Receiver end of the AER spike bus: accepts address events (one neuron address per accepted transfer) and rebuilds the per-timestep spike vector `FRAME[NEURON_NUM:0]`. It also counts spikes on the output-neuron address range over a window of timesteps. At the end of each window it reports the winning output neuron (classification readout). It sits after the AER encoder / neuron array and feeds the result display and the training-accuracy logic.

---
 rtl/aer_spike_decoder.sv | 156 +++++++++++++++
 tb/tb_aer_spike_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aer_spike_decoder.sv
// AER receiver: rebuilds per-timestep spike frames from address events and
// reports the most active output neuron at the end of every window.
module aer_spike_decoder #(
  parameter int NEURON_ADR   = 6,
  parameter int NEURON_NUM   = 68,
  parameter int OUT_BASE     = 59,
  parameter int OUT_NUM      = 10,
  parameter int WINDOW_STEPS = 16,
  parameter int CNT_W        = 8,
  parameter int WIN_W        = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EV_VALID,
  input  logic [NEURON_ADR:0]   EV_ADDR,
  output logic                  EV_READY,
  input  logic                  STEP_END,
  output logic [NEURON_NUM:0]   FRAME,
  output logic                  FRAME_VALID,
  output logic [WIN_W-1:0]      WINNER,
  output logic [CNT_W-1:0]      WIN_COUNT,
  output logic                  WIN_VALID,
  output logic                  NO_SPIKE,
  output logic                  ERR_ADDR,
  output logic                  ERR_OVERRUN
);

  localparam int STW = $clog2(WINDOW_STEPS + 1);
  localparam int SCW = $clog2(OUT_NUM + 1);
  localparam logic [STW-1:0]      STEP_LAST = STW'(WINDOW_STEPS - 1);
  localparam logic [SCW-1:0]      SCAN_LAST = SCW'(OUT_NUM - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
  localparam logic [NEURON_ADR:0] MAX_ADDR  = (NEURON_ADR + 1)'(NEURON_NUM);

  typedef enum logic [1:0] {COLLECT, EMIT, SCAN, REPORT} state_t;

  state_t                          state_reg, state_next;
  logic                            accept;
  logic [NEURON_NUM:0]             acc_reg, set_vec, acc_merged, frame_reg;
  logic [OUT_NUM-1:0][CNT_W-1:0]   cnt_reg, cnt_next;
  logic [STW-1:0]                  step_cnt_reg;
  logic [SCW-1:0]                  scan_idx_reg;
  logic [CNT_W-1:0]                best_reg, best_next, win_count_reg;
  logic [WIN_W-1:0]                best_idx_reg, best_idx_next, winner_reg;
  logic                            no_spike_reg, err_addr_reg, err_overrun_reg;

  assign accept = EV_VALID && (state_reg == COLLECT);

  // One-hot decode of the event address; out-of-range addresses hit no bit.
  generate
    for (genvar gi = 0; gi <= NEURON_NUM; gi++) begin : g_decode
      assign set_vec[gi] = accept && (EV_ADDR == (NEURON_ADR + 1)'(gi));
    end
  endgenerate

  assign acc_merged = acc_reg | set_vec;

  // A counter only advances on the first spike of its neuron within a step.
  generate
    for (genvar gi = 0; gi < OUT_NUM; gi++) begin : g_cnt
      logic hit;
      assign hit = set_vec[OUT_BASE + gi] && !acc_reg[OUT_BASE + gi];
      assign cnt_next[gi] = (state_reg == REPORT) ? '0 :
                            (hit && cnt_reg[gi] != CNT_MAX) ? cnt_reg[gi] + CNT_W'(1) :
                            cnt_reg[gi];
    end
  endgenerate

  always_comb begin
    best_next     = best_reg;
    best_idx_next = best_idx_reg;
    if (cnt_reg[scan_idx_reg] > best_reg) begin
      best_next     = cnt_reg[scan_idx_reg];
      best_idx_next = WIN_W'(scan_idx_reg);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= COLLECT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (STEP_END) state_next = EMIT;
      EMIT:    state_next = (step_cnt_reg == STEP_LAST) ? SCAN : COLLECT;
      SCAN:    if (scan_idx_reg == SCAN_LAST) state_next = REPORT;
      REPORT:  state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_reg         <= '0;
      frame_reg       <= '0;
      cnt_reg         <= '0;
      step_cnt_reg    <= '0;
      scan_idx_reg    <= '0;
      best_reg        <= '0;
      best_idx_reg    <= '0;
      winner_reg      <= '0;
      win_count_reg   <= '0;
      no_spike_reg    <= 1'b0;
      err_addr_reg    <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (STEP_END && state_reg != COLLECT) err_overrun_reg <= 1'b1;
      case (state_reg)
        COLLECT: begin
          if (accept && EV_ADDR > MAX_ADDR) err_addr_reg <= 1'b1;
          // Frame is captured here so it is already visible during EMIT.
          if (STEP_END) begin
            frame_reg <= acc_merged;
            acc_reg   <= '0;
          end else begin
            acc_reg   <= acc_merged;
          end
        end
        EMIT: begin
          if (step_cnt_reg != STEP_LAST) step_cnt_reg <= step_cnt_reg + STW'(1);
        end
        SCAN: begin
          best_reg     <= best_next;
          best_idx_reg <= best_idx_next;
          scan_idx_reg <= scan_idx_reg + SCW'(1);
          if (scan_idx_reg == SCAN_LAST) begin
            winner_reg    <= best_idx_next;
            win_count_reg <= best_next;
            no_spike_reg  <= (best_next == '0);
          end
        end
        REPORT: begin
          step_cnt_reg <= '0;
          scan_idx_reg <= '0;
          best_reg     <= '0;
          best_idx_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign EV_READY    = (state_reg == COLLECT) && !RST;
  assign FRAME_VALID = (state_reg == EMIT) && !RST;
  assign WIN_VALID   = (state_reg == REPORT) && !RST;
  assign FRAME       = frame_reg;
  assign WINNER      = winner_reg;
  assign WIN_COUNT   = win_count_reg;
  assign NO_SPIKE    = no_spike_reg;
  assign ERR_ADDR    = err_addr_reg;
  assign ERR_OVERRUN = err_overrun_reg;

endmodule

// File: tb/tb_aer_spike_decoder.sv
// Bench for aer_spike_decoder: event-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_aer_spike_decoder;

  localparam int NA = 6, NN = 68, OB = 59, ON = 10, WS = 2, CW = 8, WW = 4;

  logic          CLK = 0, RST = 1, EV_VALID = 0, STEP_END = 0;
  logic [NA:0]   EV_ADDR = '0;
  logic          EV_READY, FRAME_VALID, WIN_VALID, NO_SPIKE, ERR_ADDR, ERR_OVERRUN;
  logic [NN:0]   FRAME;
  logic [WW-1:0] WINNER;
  logic [CW-1:0] WIN_COUNT;

  aer_spike_decoder #(.NEURON_ADR(NA), .NEURON_NUM(NN), .OUT_BASE(OB), .OUT_NUM(ON),
                      .WINDOW_STEPS(WS), .CNT_W(CW), .WIN_W(WW)) dut (
    .CLK(CLK), .RST(RST), .EV_VALID(EV_VALID), .EV_ADDR(EV_ADDR), .EV_READY(EV_READY),
    .STEP_END(STEP_END), .FRAME(FRAME), .FRAME_VALID(FRAME_VALID), .WINNER(WINNER),
    .WIN_COUNT(WIN_COUNT), .WIN_VALID(WIN_VALID), .NO_SPIKE(NO_SPIKE),
    .ERR_ADDR(ERR_ADDR), .ERR_OVERRUN(ERR_OVERRUN));

  always #5 CLK = ~CLK;

  int total = 0, bad = 0, win_pulses = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: sets, counts and timestamps of the expected pulses.
  bit [NN:0] m_acc, m_frame;
  int        m_cnt [ON];
  int        m_cycle = 0, m_ready_at = 0, m_fv_at = -1, m_wv_at = -1, m_step = 0;
  int        m_winner = 0, m_wcount = 0, p_winner = 0, p_wcount = 0;
  bit        m_nospike = 0, p_nospike = 0, m_err_addr = 0, m_err_ovr = 0, m_busy;

  always @(posedge CLK) begin
    if (RST) begin
      m_acc = '0; m_frame = '0; m_step = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ready_at = m_cycle + 1; m_fv_at = -1; m_wv_at = -1;
      m_winner = 0; m_wcount = 0; m_nospike = 0; m_err_addr = 0; m_err_ovr = 0;
    end else begin
      m_busy = m_cycle < m_ready_at;
      if (EV_VALID && !m_busy) begin
        if (int'(EV_ADDR) <= NN) begin
          if (int'(EV_ADDR) >= OB && int'(EV_ADDR) < OB + ON && !m_acc[EV_ADDR])
            if (m_cnt[EV_ADDR - OB] < 255) m_cnt[EV_ADDR - OB]++;
          m_acc[EV_ADDR] = 1'b1;
        end else m_err_addr = 1;
      end
      if (STEP_END) begin
        if (m_busy) m_err_ovr = 1;
        else begin
          m_frame = m_acc; m_acc = '0; m_fv_at = m_cycle + 1; m_step++;
          if (m_step == WS) begin
            p_winner = 0; p_wcount = 0;
            for (int i = 0; i < ON; i++)
              if (m_cnt[i] > p_wcount) begin p_wcount = m_cnt[i]; p_winner = i; end
            p_nospike = (p_wcount == 0);
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_step = 0;
            m_wv_at = m_cycle + 2 + ON; m_ready_at = m_cycle + 3 + ON;
          end else m_ready_at = m_cycle + 2;
        end
      end
    end
    m_cycle++;
    if (m_cycle == m_wv_at) begin
      m_winner = p_winner; m_wcount = p_wcount; m_nospike = p_nospike;
    end
  end

  always @(negedge CLK) begin
    chk("ev_ready", EV_READY, !RST && m_cycle >= m_ready_at);
    chk("frame_valid", FRAME_VALID, !RST && m_cycle == m_fv_at);
    chk("win_valid", WIN_VALID, !RST && m_cycle == m_wv_at);
    chk("frame", FRAME, m_frame);
    chk("winner", WINNER, m_winner);
    chk("win_count", WIN_COUNT, m_wcount);
    chk("no_spike", NO_SPIKE, m_nospike);
    chk("err_addr", ERR_ADDR, m_err_addr);
    chk("err_overrun", ERR_OVERRUN, m_err_ovr);
    if (WIN_VALID) win_pulses++;
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wait_ready();
    for (int n = 0; ; n++) begin
      @(negedge CLK);
      if (EV_READY) break;
      if (n > 40) begin
        total++; bad++;
        $display("FAIL ready_timeout: got 0 expected 1");
        break;
      end
      tick();
    end
  endtask

  task automatic send(input int a, input bit se);
    wait_ready();
    EV_VALID = 1; EV_ADDR = (NA + 1)'(a); STEP_END = se;
    tick();
    EV_VALID = 0; STEP_END = 0;
  endtask

  task automatic end_step();
    wait_ready();
    STEP_END = 1;
    tick();
    STEP_END = 0;
  endtask

  task automatic wait_win(output int n);
    n = 1;
    forever begin
      @(negedge CLK);
      if (WIN_VALID) break;
      if (n > 60) begin
        total++; bad++;
        $display("FAIL win_timeout: got 0 expected 1");
        break;
      end
      tick(); n++;
    end
  endtask

  task automatic check_win(input string tag, input int w, input int c, input bit ns);
    int n;
    wait_win(n);
    chk({tag, "_winner"}, WINNER, w);
    chk({tag, "_count"}, WIN_COUNT, c);
    chk({tag, "_no_spike"}, NO_SPIKE, ns);
  endtask

  initial begin
    logic [NN:0] exp_f;
    int n, pulses;
    repeat (3) tick();
    @(negedge CLK);
    chk("reset_frame", FRAME, 0);
    chk("reset_ready", EV_READY, 0);
    tick(); RST = 0;
    @(negedge CLK);
    chk("ready_after_reset", EV_READY, 1);

    // Frame rebuild, one-cycle EV_READY drop.
    send(3, 0); send(59, 0); send(68, 0); end_step();
    @(negedge CLK);
    exp_f = '0; exp_f[3] = 1; exp_f[59] = 1; exp_f[68] = 1;
    chk("t1_frame_valid", FRAME_VALID, 1);
    chk("t1_frame", FRAME, exp_f);
    chk("t1_ready_low", EV_READY, 0);
    tick(); @(negedge CLK);
    chk("t1_ready_back", EV_READY, 1);
    end_step();
    check_win("t1", 0, 1, 0);

    // Duplicates counted once; last event rides along with STEP_END.
    send(61, 0); send(61, 0); send(62, 0); end_step();
    send(61, 0); send(64, 1);
    wait_win(n);
    chk("t2_latency", n, 12);
    chk("t2_winner", WINNER, 2);
    chk("t2_count", WIN_COUNT, 2);
    chk("t2_no_spike", NO_SPIKE, 0);

    // Tie goes to the lowest index.
    send(65, 0); send(60, 0); end_step(); end_step();
    check_win("t3", 1, 1, 0);

    // Empty window.
    end_step();
    @(negedge CLK);
    chk("t4_frame_valid", FRAME_VALID, 1);
    chk("t4_frame_zero", FRAME, 0);
    end_step();
    check_win("t4", 0, 0, 1);

    // Bad address and overrun during SCAN.
    send(100, 0); end_step();
    @(negedge CLK);
    chk("t5_err_addr", ERR_ADDR, 1);
    chk("t5_frame_zero", FRAME, 0);
    send(60, 0); end_step();
    tick(); STEP_END = 1; tick(); STEP_END = 0;
    check_win("t5", 1, 1, 0);
    repeat (4) tick();
    @(negedge CLK);
    chk("t5_err_addr_sticky", ERR_ADDR, 1);
    chk("t5_err_ovr_sticky", ERR_OVERRUN, 1);

    // Reset during SCAN aborts the window; the next window starts from zero.
    send(62, 0); send(63, 0); end_step(); send(62, 0); end_step();
    pulses = win_pulses;
    repeat (3) tick();
    RST = 1; tick(); RST = 0;
    @(negedge CLK);
    chk("t6_frame", FRAME, 0);
    chk("t6_winner", WINNER, 0);
    chk("t6_err_addr", ERR_ADDR, 0);
    chk("t6_err_ovr", ERR_OVERRUN, 0);
    repeat (20) tick();
    chk("t6_no_win_pulse", win_pulses, pulses);
    send(67, 0); end_step(); end_step();
    check_win("t6", 8, 1, 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
